// File: rtl/de1_clk_mon.sv
// -----------------------------------------------------------------------------
// de1_clk_mon -- frequency monitor for a clock delivered as a divide-by-2
// toggle. It counts how many times the toggle changes state inside a fixed
// CLOCK50 window, then reports the count and a pass/fail against an allowed
// band. While en is high, windows run back to back. A short settle interval
// before every window lets the synchronizer flush.
//
// Parameters
//   WIN      measurement window length in CLOCK50 cycles
//   SETTLE   CLOCK50 cycles discarded before each window (must be >= 1)
//   EXP_MIN  lowest passing edge count (inclusive)
//   EXP_MAX  highest passing edge count (inclusive)
//
// Ports
//   CLOCK50     in   single clock, rising edge
//   RST         in   synchronous active-high reset
//   en          in   1 = run windows continuously, 0 = idle
//   mon_tgl     in   asynchronous toggle from the monitored domain
//   clr         in   clears err_sticky              (DE1_CLK_MON_STICKY_EN)
//   err_sticky  out  a window has failed since reset/clear (DE1_CLK_MON_STICKY_EN)
//   cnt[15:0]   out  edge count of the last completed window
//   done        out  one-cycle pulse when a window completes
//   ok          out  last completed window was inside [EXP_MIN, EXP_MAX]
//
// Optional feature: define DE1_CLK_MON_STICKY_EN to add clr / err_sticky.
// -----------------------------------------------------------------------------
module de1_clk_mon #(
    parameter int WIN     = 50000,
    parameter int SETTLE  = 16,
    parameter int EXP_MIN = 23900,
    parameter int EXP_MAX = 24100
) (
    input  logic        CLOCK50,
    input  logic        RST,
    input  logic        en,
    input  logic        mon_tgl,
`ifdef DE1_CLK_MON_STICKY_EN
    input  logic        clr,
    output logic        err_sticky,
`endif
    output logic [15:0] cnt,
    output logic        done,
    output logic        ok
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0] WIN_LAST    = 32'(WIN - 1);
    localparam logic [15:0] LIM_LO      = 16'(EXP_MIN);
    localparam logic [15:0] LIM_HI      = 16'(EXP_MAX);

    state_t      state;
    logic        sync1, sync2, sync3;
    logic [31:0] wcnt;          // cycle position inside SETTLE or MEASURE
    logic [15:0] ecnt;          // edges seen so far in the current window
    logic [15:0] ecnt_next;
    logic        tgl_edge;
    logic        pass_next;
    logic        report_load;   // last MEASURE cycle with en still high

    // Each change of the divided toggle is one full monitored clock cycle.
    assign tgl_edge = sync2 ^ sync3;

    // NOTE: always_comb assigns every output on every path, giving a default
    // first, so no latch can be inferred.
    always_comb begin
        ecnt_next = ecnt;
        if (tgl_edge && (ecnt != 16'hFFFF))
            ecnt_next = ecnt + 16'd1;
    end

    // The final count includes an edge detected in the last MEASURE cycle.
    assign pass_next   = (ecnt_next >= LIM_LO) && (ecnt_next <= LIM_HI);
    assign report_load = (state == S_MEASURE) && en && (wcnt == WIN_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge CLOCK50) begin
        if (RST) begin
            state <= S_IDLE;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            wcnt  <= '0;
            ecnt  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            ok    <= 1'b0;
        end else begin
            sync1 <= mon_tgl;
            sync2 <= sync1;
            sync3 <= sync2;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    wcnt <= '0;
                    ecnt <= '0;
                    if (en)
                        state <= S_SETTLE;
                end

                S_SETTLE: begin
                    ecnt <= '0;
                    if (!en) begin
                        state <= S_IDLE;
                        wcnt  <= '0;
                    end else if (wcnt == SETTLE_LAST) begin
                        state <= S_MEASURE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                end

                S_MEASURE: begin
                    if (!en) begin
                        // Partial window is discarded; cnt/ok keep old values.
                        state <= S_IDLE;
                        wcnt  <= '0;
                        ecnt  <= '0;
                    end else if (report_load) begin
                        state <= S_REPORT;
                        ecnt  <= ecnt_next;
                        cnt   <= ecnt_next;
                        ok    <= pass_next;
                        done  <= 1'b1;
                    end else begin
                        ecnt <= ecnt_next;
                        wcnt <= wcnt + 32'd1;
                    end
                end

                S_REPORT: begin
                    // Edges in this cycle belong to no window.
                    wcnt  <= '0;
                    ecnt  <= '0;
                    state <= en ? S_SETTLE : S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DE1_CLK_MON_STICKY_EN
    // A failing report and a clear in the same cycle leave the flag set.
    always_ff @(posedge CLOCK50) begin
        if (RST)
            err_sticky <= 1'b0;
        else if (report_load && !pass_next)
            err_sticky <= 1'b1;
        else if (clr)
            err_sticky <= 1'b0;
    end
`endif

endmodule

// File: doc/de1_clk_mon.md
DE1_CLK_MON -- requirements
Module: de1_clk_mon

Interface
REQ-001 SHALL have parameter WIN, default 50000, giving measurement window length in CLOCK50 cycles (1 ms).
REQ-002 SHALL have parameter SETTLE, default 16, giving the number of CLOCK50 cycles discarded before each window.
REQ-003 SHALL have parameter EXP_MIN, default 23900, giving the lowest edge count that passes (inclusive).
REQ-004 SHALL have parameter EXP_MAX, default 24100, giving the highest edge count that passes (inclusive).
REQ-005 SHALL have port CLOCK50 input 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST input 1: reset, synchronous, active-high.
REQ-007 SHALL have port en input 1: high runs back-to-back windows; low idles.
REQ-008 SHALL have port mon_tgl input 1: asynchronous toggle from a divide-by-2 flop in the monitored clock domain (<= CLOCK50/4).
REQ-009 SHALL have port clr input 1: clears err_sticky (present only with the macro).
REQ-010 SHALL have port cnt output 16: edge count of the last completed window.
REQ-011 SHALL have port done output 1: one-cycle pulse at window completion.
REQ-012 SHALL have port ok output 1: last completed window within [EXP_MIN, EXP_MAX].
REQ-013 SHALL have port err_sticky output 1: a failing window has occurred since reset/clear (present only with the macro).

Function
REQ-014 SHALL pass mon_tgl through a 2-flop synchronizer plus a third flop; an edge is sync2 != sync3, and each edge counts as one monitored clock cycle.
REQ-015 SHALL implement FSM IDLE -> SETTLE -> MEASURE -> REPORT -> SETTLE; IDLE -> SETTLE when en=1.
REQ-016 SETTLE SHALL last exactly SETTLE cycles with the edge counter held at 0 and edges ignored.
REQ-017 MEASURE SHALL last exactly WIN cycles, counting edges detected in those cycles only.
REQ-018 The edge counter SHALL saturate at 16'hFFFF without wrap.
REQ-019 REPORT SHALL last one cycle and assert done, while cnt and ok load from the final count in that same cycle.
REQ-020 An edge in the last MEASURE cycle SHALL be included in the count; an edge in the REPORT cycle SHALL be excluded.
REQ-021 cnt and ok SHALL hold their values between done pulses.
REQ-022 en=0 in SETTLE or MEASURE SHALL return the FSM to IDLE next cycle, discard the partial count, and give no done; cnt and ok hold.
REQ-023 en=0 in REPORT SHALL still complete the report (done=1), then enter IDLE.
REQ-024 ok SHALL be 1 iff EXP_MIN <= count <= EXP_MAX; a saturated count is a fail unless EXP_MAX=16'hFFFF.

Reset
REQ-025 RST=1 SHALL force state IDLE; synchronizer flops, edge counter, window counter, cnt, done, ok and err_sticky all go to 0.
REQ-026 RST asserted mid-window SHALL abort the window with no done; measurement restarts from SETTLE in the first cycle after RST falls with en=1.

Configuration
REQ-027 Macro DE1_CLK_MON_STICKY_EN defined: clr and err_sticky exist; err_sticky sets in the REPORT cycle when ok loads 0.
REQ-028 With the macro, clr=1 clears err_sticky next cycle; a simultaneous set and clr SHALL leave err_sticky=1 (set wins).
REQ-029 Macro DE1_CLK_MON_STICKY_EN undefined: ports clr and err_sticky and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 WIN=1000, SETTLE=16, EXP 490..510, mon_tgl toggling every 2 CLOCK50 cycles, en=1 -> done every 1017 cycles, cnt=500, ok=1.
REQ-031 Same parameters, mon_tgl toggling every 4 cycles -> cnt=250, ok=0; with the macro, err_sticky=1 after the first done.
REQ-032 mon_tgl held constant -> cnt=0, ok=0; then clr pulse -> err_sticky=0 and re-set at the next done.
REQ-033 en dropped at MEASURE cycle 600 -> no done, cnt and ok unchanged; en re-raised -> the first done arrives 1017 cycles later.
REQ-034 RST pulsed for 1 cycle mid-MEASURE -> all outputs 0, no done, then normal windows resume.
REQ-035 EXP_MAX=16'hFFFF, WIN=70000, mon_tgl toggling every cycle -> cnt=16'hFFFF saturated, ok=1.
